mux_rr_scheduler: RTL

Round-robin scheduler that shares one 8-to-1 delay mux (`mux8to1_delay`) among eight requesters by driving its `sel` and `en` pins. The block grants one requester at a time for a bounded dwell and breaks before it makes: `en` goes low across every select change so mux propagation delay never produces a glitched output. It sits directly in front of the mux; requesters see a one-hot `grant`.

---
 rtl/mux_rr_scheduler_pkg.sv | 11 +
 rtl/mux_rr_scheduler_rr_pick8.sv | 21 ++
 rtl/mux_rr_scheduler.sv | 77 +++++++
 3 files changed

// File: rtl/mux_rr_scheduler_pkg.sv
// mux_rr_scheduler_pkg: shared widths, reset pointer and FSM encoding for the mux scheduler
package mux_rr_scheduler_pkg;
  localparam int NREQ = 8;
  localparam int SELW = 3;
  localparam logic [SELW-1:0] LAST_RST = 3'd7;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWITCH = 2'd1,
    GRANT  = 2'd2
  } state_t;
endpackage

// File: rtl/mux_rr_scheduler_rr_pick8.sv
// rr_pick8: combinational round-robin search starting after last, last itself lowest priority
module rr_pick8
  import mux_rr_scheduler_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [SELW-1:0] last,
  output logic            found,
  output logic [SELW-1:0] win
);
  logic [SELW-1:0] idx;
  // scan from the farthest offset down so the nearest requester after last overwrites the rest
  always_comb begin
    found = |req;
    win = last;
    idx = last;
    for (int i = NREQ - 1; i >= 1; i--) begin
      idx = last + SELW'(i);
      win = req[idx] ? idx : win;
    end
  end
endmodule

// File: rtl/mux_rr_scheduler.sv
// mux_rr_scheduler: round-robin, break-before-make driver for a shared 8:1 delay mux
module mux_rr_scheduler
  import mux_rr_scheduler_pkg::*;
#(
  parameter int DWELL  = 4,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [SELW-1:0] sel,
  output logic            en,
  output logic [NREQ-1:0] grant,
  output logic            busy
);
  localparam logic [7:0] DW = 8'(DWELL - 1);
  localparam logic [7:0] ST = 8'(SETTLE - 1);
  state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [SELW-1:0] last, last_n, sel_n, win;
  logic en_n, found, arb;
  rr_pick8 u_pick (
    .req  (req),
    .last (last),
    .found(found),
    .win  (win)
  );
  // settle expiry hands the mux over; release, dwell expiry or idle trigger a fresh arbitration
  always_comb begin
    state_n = state;
    sel_n = sel;
    en_n = en;
    cnt_n = cnt;
    last_n = last;
    arb = state == GRANT ? (!req[sel] || cnt == 8'd0) : state == SWITCH ? !req[sel] : 1'b1;
    if (state == SWITCH && req[sel] && cnt == 8'd0) begin
      state_n = GRANT;
      en_n = 1'b1;
      cnt_n = DW;
      last_n = sel;
    end else if (arb && !found) begin
      state_n = IDLE;
      en_n = 1'b0;
    end else if (arb && win == sel) begin
      state_n = GRANT;
      en_n = 1'b1;
      cnt_n = DW;
      last_n = win;
    end else if (arb) begin
      state_n = SWITCH;
      sel_n = win;
      en_n = 1'b0;
      cnt_n = ST;
    end else begin
      cnt_n = cnt - 8'd1;
    end
  end
  // state and output registers; grant is derived from the next sel/en so it always matches the pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel <= '0;
      en <= 1'b0;
      grant <= '0;
      cnt <= 8'd0;
      last <= LAST_RST;
    end else begin
      state <= state_n;
      sel <= sel_n;
      en <= en_n;
      grant <= en_n ? {{(NREQ-1){1'b0}}, 1'b1} << sel_n : '0;
      cnt <= cnt_n;
      last <= last_n;
    end
  end
  assign busy = state != IDLE;
endmodule
